inst_mem: RTL and testbench

Instruction memory responder for the core's fetch port: it serves `inst_i` for every `inst_addr_o` the core presents. It also contains a byte-serial loader that fills the memory from an external byte stream while holding the core. It sits beside the core top, driving the core's `inst_i` from the core's `inst_addr_o`, and driving the core's reset/hold gating through `core_hold_o`.

---
 rtl/soc_pkg.sv | 21 ++
 rtl/inst_mem_array.sv | 38 +++
 rtl/inst_mem.sv | 165 ++++++++++++++++
 tb/tb_inst_mem.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_pkg.sv
// -----------------------------------------------------------------------------
// soc_pkg
// Definitions shared by the instruction memory and its neighbours:
//   NOP_INST            - instruction returned for fetches outside the array
//   DEFAULT_DEPTH_WORDS - default instruction memory depth (32-bit words)
//   ld_state_t          - byte-serial loader states
// -----------------------------------------------------------------------------
package soc_pkg;

    localparam logic [31:0] NOP_INST            = 32'h0000_0013;
    localparam int          DEFAULT_DEPTH_WORDS = 4096;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LEN0 = 3'd1,
        LEN1 = 3'd2,
        DATA = 3'd3,
        DONE = 3'd4
    } ld_state_t;

endpackage : soc_pkg

// File: rtl/inst_mem_array.sv
// -----------------------------------------------------------------------------
// inst_mem_array
// Word array with one synchronous write port and one asynchronous read port.
// A write and a read of the same word in one cycle returns the old word.
//   clk      - write clock
//   we_i     - write enable
//   waddr_i  - write word index
//   wdata_i  - write data
//   raddr_i  - read word index
//   rdata_o  - read data (combinational)
// -----------------------------------------------------------------------------
module inst_mem_array
    import soc_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [31:0]   wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // NOTE: the array has no reset on purpose; contents must survive reset,
    // and a reset branch would also stop the array mapping onto RAM macros.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : inst_mem_array

// File: rtl/inst_mem.sv
// -----------------------------------------------------------------------------
// inst_mem
// Instruction memory for the core fetch port plus a byte-serial loader.
// Load stream: 2-byte little-endian word count N, then 4*N bytes forming
// little-endian words written to word 0..N-1. The core is held while loading.
//   clk          - clock
//   rst          - asynchronous active-low reset
//   inst_addr_i  - fetch byte address
//   inst_o       - instruction word (combinational, NOP when out of range)
//   ld_start_i   - pulse opening a load session (ignored unless idle)
//   ld_valid_i   - stream byte valid
//   ld_data_i    - stream byte
//   ld_ready_o   - stream ready
//   core_hold_o  - high while a session is open
//   ld_done_o    - one-cycle pulse at session end
//   ld_err_o     - sticky: last session overflowed the array
// DEPTH_WORDS must be a power of two and no larger than 65536.
// -----------------------------------------------------------------------------
module inst_mem
    import soc_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_addr_i,
    output logic [31:0] inst_o,
    input  logic        ld_start_i,
    input  logic        ld_valid_i,
    input  logic [7:0]  ld_data_i,
    output logic        ld_ready_o,
    output logic        core_hold_o,
    output logic        ld_done_o,
    output logic        ld_err_o
);

    // Pointer is one bit wider than the count so it never wraps.
    localparam logic [16:0] DEPTH_LIM = 17'(DEPTH_WORDS);

    ld_state_t   state_q, state_d;
    logic [15:0] count_q, count_d;
    logic [16:0] ptr_q, ptr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] asm_q, asm_d;
    logic        err_q, err_d;

    logic        accept;
    logic        wr_en;
    logic [31:0] rd_data;
    logic        addr_out_of_range;
    logic        unused_addr_bits;

    // ------------------------------------------------------------------ read
    inst_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (ptr_q[AW-1:0]),
        .wdata_i (asm_d),
        .raddr_i (inst_addr_i[AW+1:2]),
        .rdata_o (rd_data)
    );

    assign addr_out_of_range = (inst_addr_i >> (AW + 2)) != '0;
    assign inst_o            = addr_out_of_range ? NOP_INST : rd_data;
    // Byte offset within a word is irrelevant to a word fetch.
    assign unused_addr_bits  = &{1'b0, inst_addr_i[1:0]};

    // ---------------------------------------------------------------- loader
    assign accept = ld_valid_i && ld_ready_o;

    always_comb begin
        // NOTE: every signal gets its default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        count_d    = count_q;
        ptr_d      = ptr_q;
        byte_cnt_d = byte_cnt_q;
        asm_d      = asm_q;
        err_d      = err_q;
        wr_en      = 1'b0;
        ld_ready_o = 1'b0;
        core_hold_o = 1'b1;
        ld_done_o  = 1'b0;

        unique case (state_q)
            IDLE: begin
                core_hold_o = 1'b0;
                if (ld_start_i) begin
                    state_d    = LEN0;
                    err_d      = 1'b0;
                    ptr_d      = '0;
                    byte_cnt_d = '0;
                end
            end
            LEN0: begin
                ld_ready_o = 1'b1;
                if (accept) begin
                    count_d[7:0] = ld_data_i;
                    state_d      = LEN1;
                end
            end
            LEN1: begin
                ld_ready_o = 1'b1;
                if (accept) begin
                    count_d[15:8] = ld_data_i;
                    state_d = ({ld_data_i, count_q[7:0]} == 16'd0) ? DONE : DATA;
                end
            end
            DATA: begin
                ld_ready_o = 1'b1;
                if (accept) begin
                    // asm_d carries the completed word on the 4th byte, so it
                    // doubles as the write data.
                    asm_d[{byte_cnt_q, 3'b000} +: 8] = ld_data_i;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (ptr_q < DEPTH_LIM) begin
                            wr_en = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                        ptr_d = ptr_q + 17'd1;
                        if (ptr_q + 17'd1 == {1'b0, count_q}) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                ld_done_o = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its pre-edge value, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            count_q    <= '0;
            ptr_q      <= '0;
            byte_cnt_q <= '0;
            asm_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ptr_q      <= ptr_d;
            byte_cnt_q <= byte_cnt_d;
            asm_q      <= asm_d;
            err_q      <= err_d;
        end
    end

    assign ld_err_o = err_q;

endmodule : inst_mem

// File: tb/tb_inst_mem.sv
// -----------------------------------------------------------------------------
// tb_inst_mem
// Directed bench for inst_mem. Two instances share all inputs: dut_a with the
// default 4096-word depth and dut_b with a 4-word depth, so the overflow case
// can be compared against a non-overflowing reference on the same stream.
// -----------------------------------------------------------------------------
module tb_inst_mem;
    import soc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_addr_i;
    logic        ld_start_i;
    logic        ld_valid_i;
    logic [7:0]  ld_data_i;

    logic [31:0] inst_a, inst_b;
    logic        ready_a, ready_b, hold_a, hold_b, done_a, done_b, err_a, err_b;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] stream [$];

    always #5 clk = ~clk;

    inst_mem #(.DEPTH_WORDS(4096)) dut_a (
        .clk         (clk),
        .rst         (rst),
        .inst_addr_i (inst_addr_i),
        .inst_o      (inst_a),
        .ld_start_i  (ld_start_i),
        .ld_valid_i  (ld_valid_i),
        .ld_data_i   (ld_data_i),
        .ld_ready_o  (ready_a),
        .core_hold_o (hold_a),
        .ld_done_o   (done_a),
        .ld_err_o    (err_a)
    );

    inst_mem #(.DEPTH_WORDS(4)) dut_b (
        .clk         (clk),
        .rst         (rst),
        .inst_addr_i (inst_addr_i),
        .inst_o      (inst_b),
        .ld_start_i  (ld_start_i),
        .ld_valid_i  (ld_valid_i),
        .ld_data_i   (ld_data_i),
        .ld_ready_o  (ready_b),
        .core_hold_o (hold_b),
        .ld_done_o   (done_b),
        .ld_err_o    (err_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push_count(input logic [15:0] n);
        stream.push_back(n[7:0]);
        stream.push_back(n[15:8]);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            stream.push_back(w[8*i +: 8]);
        end
    endtask

    // Runs one session with the queued stream. With gaps set, valid is low on
    // every odd cycle after the start. Returns the number of cycles with
    // core_hold_o high, the cycle (counted from the start edge) of the done
    // pulse, and the number of done pulses seen on dut_b.
    task automatic load(input bit gaps, output int hold_cycles, output int done_at,
                        output int done_b_cnt);
        int cyc;
        int idx;
        @(negedge clk);
        ld_start_i = 1'b1;
        @(posedge clk);
        #1;
        ld_start_i  = 1'b0;
        cyc         = 1;
        idx         = 0;
        hold_cycles = 0;
        done_at     = -1;
        done_b_cnt  = 0;
        while (hold_a && cyc < 300) begin
            hold_cycles++;
            if (done_a) done_at = cyc;
            if (done_b) done_b_cnt++;
            if (ready_a && idx < stream.size() && !(gaps && cyc[0])) begin
                ld_valid_i = 1'b1;
                ld_data_i  = stream[idx];
                idx++;
            end else begin
                ld_valid_i = 1'b0;
                ld_data_i  = 8'h00;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        ld_valid_i = 1'b0;
        check("load_terminates", 32'(cyc < 300), 32'd1);
        check("all_bytes_sent", idx, stream.size());
        stream.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        ld_valid_i = 1'b1;
        ld_data_i  = b;
        @(posedge clk);
        #1;
        ld_valid_i = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_a, input logic [31:0] exp_b);
        @(negedge clk);
        inst_addr_i = addr;
        #1;
        check({tag, "_a"}, inst_a, exp_a);
        check({tag, "_b"}, inst_b, exp_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, d, db;
        rst         = 1'b0;
        inst_addr_i = 32'h0;
        ld_start_i  = 1'b0;
        ld_valid_i  = 1'b0;
        ld_data_i   = 8'h00;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_a", 32'(ready_a), 32'd0);
        check("rst_hold_a",  32'(hold_a),  32'd0);
        check("rst_done_a",  32'(done_a),  32'd0);
        check("rst_err_a",   32'(err_a),   32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("idle_ready_b", 32'(ready_b), 32'd0);
        check("idle_hold_b",  32'(hold_b),  32'd0);
        check("idle_err_b",   32'(err_b),   32'd0);

        // Preload words 0..3, word 3 = DEADBEEF
        push_count(16'd4);
        push_word(32'h1111_1111);
        push_word(32'h2222_2222);
        push_word(32'h3333_3333);
        push_word(32'hDEAD_BEEF);
        load(1'b0, h, d, db);
        check("pre_done_at", d, 32'd19);
        check("pre_hold",    h, 32'd19);
        rd_check("rd_0x0c",   32'h0000_000C, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        rd_check("rd_0x0e",   32'h0000_000E, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        rd_check("rd_oor",    32'h0001_0000, NOP_INST,      NOP_INST);
        rd_check("rd_0x04",   32'h0000_0004, 32'h2222_2222, 32'h2222_2222);

        // Two-word stream, valid held high
        push_count(16'd2);
        push_word(32'h0010_0093);
        push_word(32'h0020_0113);
        load(1'b0, h, d, db);
        check("s2_done_at", d,  32'd11);
        check("s2_hold",    h,  32'd11);
        check("s2_done_b",  db, 32'd1);
        rd_check("s2_w0", 32'h0, 32'h0010_0093, 32'h0010_0093);
        rd_check("s2_w1", 32'h4, 32'h0020_0113, 32'h0020_0113);
        rd_check("s2_w2", 32'h8, 32'h3333_3333, 32'h3333_3333);

        // Overwrite, then same stream with valid toggling
        push_count(16'd2);
        push_word(32'hAAAA_AAAA);
        push_word(32'hBBBB_BBBB);
        load(1'b0, h, d, db);
        rd_check("ow_w0", 32'h0, 32'hAAAA_AAAA, 32'hAAAA_AAAA);
        push_count(16'd2);
        push_word(32'h0010_0093);
        push_word(32'h0020_0113);
        load(1'b1, h, d, db);
        check("gap_done_at", d, 32'd21);
        check("gap_hold",    h, 32'd21);
        rd_check("gap_w0", 32'h0, 32'h0010_0093, 32'h0010_0093);
        rd_check("gap_w1", 32'h4, 32'h0020_0113, 32'h0020_0113);
        rd_check("gap_w2", 32'h8, 32'h3333_3333, 32'h3333_3333);

        // Zero-length session
        push_count(16'd0);
        load(1'b0, h, d, db);
        check("z_done_at", d, 32'd3);
        check("z_hold",    h, 32'd3);
        check("z_err_a", 32'(err_a), 32'd0);
        check("z_err_b", 32'(err_b), 32'd0);
        rd_check("z_w0", 32'h0, 32'h0010_0093, 32'h0010_0093);

        // Six words: overflows dut_b (4 words), fits dut_a
        push_count(16'd6);
        for (int k = 0; k < 6; k++) begin
            push_word(32'hA000_0000 | 32'(k));
        end
        load(1'b0, h, d, db);
        check("ov_done_at", d,  32'd27);
        check("ov_done_b",  db, 32'd1);
        check("ov_err_a", 32'(err_a), 32'd0);
        check("ov_err_b", 32'(err_b), 32'd1);
        rd_check("ov_w0", 32'h00, 32'hA000_0000, 32'hA000_0000);
        rd_check("ov_w1", 32'h04, 32'hA000_0001, 32'hA000_0001);
        rd_check("ov_w3", 32'h0C, 32'hA000_0003, 32'hA000_0003);
        rd_check("ov_w4", 32'h10, 32'hA000_0004, NOP_INST);
        rd_check("ov_w5", 32'h14, 32'hA000_0005, NOP_INST);
        @(posedge clk);
        #1;
        check("ov_err_sticky_b", 32'(err_b), 32'd1);

        // Start clears the error; reset after 5 data bytes aborts the session
        @(negedge clk);
        ld_start_i = 1'b1;
        @(posedge clk);
        #1;
        ld_start_i = 1'b0;
        check("st_err_clr_b", 32'(err_b), 32'd0);
        check("st_hold_a",    32'(hold_a), 32'd1);
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h44);
        send_byte(8'h33);
        send_byte(8'h22);
        send_byte(8'h11);
        send_byte(8'h55);
        check("mid_hold_before", 32'(hold_a), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_hold_a",  32'(hold_a),  32'd0);
        check("mid_hold_b",  32'(hold_b),  32'd0);
        check("mid_ready_a", 32'(ready_a), 32'd0);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd_check("mid_w0", 32'h0, 32'h1122_3344, 32'h1122_3344);
        rd_check("mid_w1", 32'h4, 32'hA000_0001, 32'hA000_0001);

        // New session after the aborted one
        push_count(16'd1);
        push_word(32'hCAFE_F00D);
        load(1'b0, h, d, db);
        check("re_done_at", d, 32'd7);
        check("re_hold",    h, 32'd7);
        rd_check("re_w0", 32'h0, 32'hCAFE_F00D, 32'hCAFE_F00D);
        rd_check("re_w1", 32'h4, 32'hA000_0001, 32'hA000_0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_inst_mem
